// File: rtl/life_step_engine.sv
// Game-of-Life generation engine: the displayed grid is double-buffered, the next
// generation is built one row per clock in a shadow buffer, then committed at once.
module life_step_engine #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter bit WRAP = 1'b1,
  parameter int GENW = 16
) (
  input  logic                           clk,
  input  logic                           _rst,
  input  logic                           step,
  input  logic                           load_en,
  input  logic [$clog2(ROWS)-1:0]        load_row,
  input  logic [COLS-1:0]                load_data,
  output logic                           busy,
  output logic                           done,
  output logic [ROWS*COLS-1:0]           grid_flat,
  output logic [GENW-1:0]                gen_count,
  output logic [$clog2(ROWS*COLS+1)-1:0] population,
  output logic                           stable
);
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(ROWS*COLS+1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS-1);

  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

  state_t                    state;
  logic [RW-1:0]             row;
  logic [ROWS-1:0][COLS-1:0] cur;
  logic [ROWS-1:0][COLS-1:0] shadow;
  logic [ROWS-1:0][COLS-1:0] loaded;
  logic [COLS-1:0]           up;
  logic [COLS-1:0]           mid;
  logic [COLS-1:0]           dn;
  logic [COLS-1:0]           next_row;
  logic [COLS+1:0]           up_x;
  logic [COLS+1:0]           mid_x;
  logic [COLS+1:0]           dn_x;
  logic [3:0]                n;
  logic                      load_ok;

  function automatic logic [PW-1:0] popcount(input logic [ROWS*COLS-1:0] v);
    logic [PW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < ROWS*COLS; i++) cnt = cnt + PW'(v[i]);
    return cnt;
  endfunction

  // Extends a row by one cell on each side so every column sees three neighbours.
  function automatic logic [COLS+1:0] pad(input logic [COLS-1:0] v);
    return {(WRAP ? v[0] : 1'b0), v, (WRAP ? v[COLS-1] : 1'b0)};
  endfunction

  always_comb begin
    up  = '0;
    dn  = '0;
    mid = cur[row];
    if (row != '0) up = cur[row - 1'b1];
    else if (WRAP) up = cur[LAST_ROW];
    if (row != LAST_ROW) dn = cur[row + 1'b1];
    else if (WRAP) dn = cur[0];
  end

  always_comb begin
    next_row = '0;
    n        = '0;
    up_x     = pad(up);
    mid_x    = pad(mid);
    dn_x     = pad(dn);
    for (int c = 0; c < COLS; c++) begin
      n = 4'(up_x[c]) + 4'(up_x[c+1]) + 4'(up_x[c+2])
        + 4'(mid_x[c]) + 4'(mid_x[c+2])
        + 4'(dn_x[c]) + 4'(dn_x[c+1]) + 4'(dn_x[c+2]);
      next_row[c] = (n == 4'd3) || (mid[c] && (n == 4'd2));
    end
  end

  assign load_ok = 32'(load_row) < ROWS;

  always_comb begin
    loaded = cur;
    if (load_ok) loaded[load_row] = load_data;
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state      <= IDLE;
      row        <= '0;
      cur        <= '0;
      shadow     <= '0;
      gen_count  <= '0;
      population <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      stable     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_en) begin
            if (load_ok) begin
              cur        <= loaded;
              population <= popcount(loaded);
              stable     <= 1'b0;
            end
          end else if (step) begin
            state <= COMPUTE;
            row   <= '0;
            busy  <= 1'b1;
          end
        end
        COMPUTE: begin
          shadow[row] <= next_row;
          if (row == LAST_ROW) begin
            state <= COMMIT;
            row   <= '0;
          end else begin
            row <= row + 1'b1;
          end
        end
        COMMIT: begin
          cur        <= shadow;
          gen_count  <= gen_count + 1'b1;
          population <= popcount(shadow);
          stable     <= (shadow == cur);
          state      <= IDLE;
          busy       <= 1'b0;
          done       <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grid_flat = cur;

endmodule

// File: tb/tb_life_step_engine.sv
// Bench for life_step_engine: a wrapping and a non-wrapping instance share stimulus
// and are compared against a cell-by-cell Game-of-Life model.
module tb_life_step_engine;
  localparam int ROWS = 8;
  localparam int COLS = 8;

  logic        clk = 1'b0;
  logic        _rst = 1'b0;
  logic        step = 1'b0;
  logic        load_en = 1'b0;
  logic [2:0]  load_row = '0;
  logic [7:0]  load_data = '0;

  logic        busy1, done1, stable1, busy0, done0, stable0;
  logic [63:0] grid1, grid0;
  logic [15:0] gen1, gen0;
  logic [6:0]  pop1, pop0;

  int checks = 0;
  int errors = 0;

  bit mg [2][ROWS][COLS];
  bit mst [2];
  int mgen = 0;

  life_step_engine #(.ROWS(ROWS), .COLS(COLS), .WRAP(1'b1), .GENW(16)) dut_wrap (
    .clk(clk), ._rst(_rst), .step(step), .load_en(load_en), .load_row(load_row),
    .load_data(load_data), .busy(busy1), .done(done1), .grid_flat(grid1),
    .gen_count(gen1), .population(pop1), .stable(stable1)
  );

  life_step_engine #(.ROWS(ROWS), .COLS(COLS), .WRAP(1'b0), .GENW(16)) dut_nowrap (
    .clk(clk), ._rst(_rst), .step(step), .load_en(load_en), .load_row(load_row),
    .load_data(load_data), .busy(busy0), .done(done0), .grid_flat(grid0),
    .gen_count(gen0), .population(pop0), .stable(stable0)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_flat(int w);
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) v[r*COLS+c] = mg[w][r][c];
    return v;
  endfunction

  function automatic logic [63:0] model_pop(int w);
    int cnt;
    cnt = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) cnt += int'(mg[w][r][c]);
    return 64'(cnt);
  endfunction

  // One generation of the textbook rule; w=1 is a torus, w=0 a dead border.
  task automatic model_step();
    bit nxt [ROWS][COLS];
    int cnt, rr, cc;
    for (int w = 0; w < 2; w++) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          cnt = 0;
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              if (dr != 0 || dc != 0) begin
                rr = r + dr;
                cc = c + dc;
                if (w == 1) cnt += int'(mg[w][(rr + ROWS) % ROWS][(cc + COLS) % COLS]);
                else if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) cnt += int'(mg[w][rr][cc]);
              end
            end
          end
          nxt[r][c] = (cnt == 3) || (mg[w][r][c] && cnt == 2);
        end
      end
      mst[w] = 1'b1;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          if (nxt[r][c] != mg[w][r][c]) mst[w] = 1'b0;
          mg[w][r][c] = nxt[r][c];
        end
    end
    mgen = (mgen + 1) % 65536;
  endtask

  task automatic model_load(int row, logic [7:0] data);
    for (int w = 0; w < 2; w++) begin
      for (int c = 0; c < COLS; c++) mg[w][row][c] = data[c];
      mst[w] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) mg[w][r][c] = 1'b0;
      mst[w] = 1'b0;
    end
    mgen = 0;
  endtask

  task automatic check_output(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    check_output({tag, ".grid_w"}, grid1, model_flat(1));
    check_output({tag, ".pop_w"}, 64'(pop1), model_pop(1));
    check_output({tag, ".gen_w"}, 64'(gen1), 64'(mgen));
    check_output({tag, ".stable_w"}, 64'(stable1), 64'(mst[1]));
    check_output({tag, ".grid_nw"}, grid0, model_flat(0));
    check_output({tag, ".pop_nw"}, 64'(pop0), model_pop(0));
    check_output({tag, ".gen_nw"}, 64'(gen0), 64'(mgen));
    check_output({tag, ".stable_nw"}, 64'(stable0), 64'(mst[0]));
  endtask

  task automatic apply_load(int row, logic [7:0] data);
    @(negedge clk);
    load_en   = 1'b1;
    load_row  = 3'(row);
    load_data = data;
    @(negedge clk);
    load_en = 1'b0;
    model_load(row, data);
    check_all("load");
  endtask

  task automatic clear_grid();
    for (int r = 0; r < ROWS; r++) apply_load(r, 8'h00);
  endtask

  // poke >= 0 pulses step and a row-5 load during that compute cycle; both must be ignored.
  task automatic apply_step(int poke);
    logic [63:0] snap;
    int n;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    snap = model_flat(1);
    n = 0;
    while (busy1 === 1'b1 && n < 30) begin
      check_output("grid_hold", grid1, snap);
      if (n == poke) begin
        step      = 1'b1;
        load_en   = 1'b1;
        load_row  = 3'd5;
        load_data = 8'hFF;
      end else begin
        step    = 1'b0;
        load_en = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    step    = 1'b0;
    load_en = 1'b0;
    check_output("busy_cycles", 64'(n), 64'd9);
    check_output("done_w", 64'(done1), 64'd1);
    check_output("done_nw", 64'(done0), 64'd1);
    check_output("busy_nw", 64'(busy0), 64'd0);
    model_step();
    check_all("step");
    @(negedge clk);
    check_output("done_clear", 64'(done1), 64'd0);
  endtask

  initial begin
    $display("[TB] life_step_engine bench start");
    model_reset();

    // Reset held with step asserted: everything stays zero.
    step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("rst.grid", grid1, 64'd0);
      check_output("rst.gen", 64'(gen1), 64'd0);
      check_output("rst.pop", 64'(pop1), 64'd0);
      check_output("rst.busy", 64'(busy1), 64'd0);
      check_output("rst.done", 64'(done1), 64'd0);
    end
    _rst = 1'b1;
    step = 1'b0;
    @(negedge clk);
    check_all("post_rst");
    check_output("post_rst.busy", 64'(busy1), 64'd0);

    // Blinker oscillates with period 2.
    apply_load(3, 8'h1C);
    apply_step(-1);
    check_output("blinker1", grid1, 64'h0000_0008_0808_0000);
    check_output("blinker1.pop", 64'(pop1), 64'd3);
    apply_step(-1);
    check_output("blinker2", grid1, 64'h0000_0000_1C00_0000);
    check_output("blinker2.gen", 64'(gen1), 64'd2);

    // Block still life raises stable; the next load drops it.
    clear_grid();
    apply_load(1, 8'h06);
    apply_load(2, 8'h06);
    apply_step(-1);
    check_output("block.stable", 64'(stable1), 64'd1);
    check_output("block.pop", 64'(pop1), 64'd4);
    apply_load(7, 8'h00);
    check_output("block.unstable", 64'(stable1), 64'd0);

    // Row 0 line: only the toroidal instance reaches row 7.
    clear_grid();
    apply_load(0, 8'h07);
    apply_step(-1);
    check_output("edge.wrap", grid1, 64'h0200_0000_0000_0202);
    check_output("edge.nowrap", grid0, 64'h0000_0000_0000_0202);

    // Step and load pulsed mid-compute are dropped.
    apply_step(3);

    // Load and step together in idle: load wins.
    @(negedge clk);
    load_en   = 1'b1;
    load_row  = 3'd5;
    load_data = 8'hFF;
    step      = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    step    = 1'b0;
    model_load(5, 8'hFF);
    check_output("both.busy", 64'(busy1), 64'd0);
    check_all("both");
    @(negedge clk);
    check_output("both.busy2", 64'(busy1), 64'd0);
    check_output("both.done", 64'(done1), 64'd0);

    // Asynchronous reset in the middle of a compute.
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
    #2 _rst = 1'b0;
    #1;
    model_reset();
    check_output("midrst.grid", grid1, 64'd0);
    check_output("midrst.busy", 64'(busy1), 64'd0);
    check_output("midrst.gen", 64'(gen1), 64'd0);
    check_output("midrst.pop", 64'(pop1), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_output("midrst.done", 64'(done1), 64'd0);
    end
    _rst = 1'b1;
    apply_step(-1);
    check_output("midrst.empty", grid1, 64'd0);
    check_output("midrst.gen1", 64'(gen1), 64'd1);

    // Random soups evolved for a few generations.
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < ROWS; r++) apply_load(r, 8'($urandom) & 8'($urandom | 32'h55));
      repeat (3) apply_step(-1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_step_engine.md
Name: life_step_engine

Overview:
- Game-of-Life generation engine; sits directly upstream of the LED-matrix row-scan stage and supplies the cell grid it displays.
- Holds the current generation in a register array and computes the next generation one row per clock into a shadow buffer.
- Commits the whole grid atomically, so the scanner never sees a half-updated frame.
- Also provides a row-wise seed/load port, a generation counter, a population count and a still-life flag.

Parameters:
- ROWS, 8, grid height; 2..16.
- COLS, 8, grid width; 2..16.
- WRAP, 1. 1 = toroidal edges (indices taken modulo ROWS/COLS). 0 = cells outside the grid count as dead.
- GENW, 16, width of the generation counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- _rst  in  1  asynchronous active-low reset.
- step  in  1  request one generation; sampled only in IDLE.
- load_en  in  1  write load_data into grid row load_row; sampled only in IDLE.
- load_row  in  clog2(ROWS)  target row for load.
- load_data  in  COLS  row contents; bit c = column c.
- busy  out  1  high while COMPUTE or COMMIT.
- done  out  1  one-cycle pulse in the cycle after commit.
- grid_flat  out  ROWS*COLS  current generation; bit r*COLS+c = cell (r,c).
- gen_count  out  GENW  generations committed since reset.
- population  out  clog2(ROWS*COLS+1)  live cells in grid_flat.
- stable  out  1  last committed generation equalled its predecessor.

Behaviour:
- Reset (async, _rst low) forces:
  - grid, shadow, gen_count, population all zero;
  - busy=0, done=0, stable=0;
  - state=IDLE, row index=0.
- Reset mid-operation aborts the computation. No done pulse is issued and the grid is cleared.
- State machine:
  - IDLE:
    - load_en=1 writes cur[load_row]=load_data at the next edge. population updates the same edge. stable clears.
    - Otherwise, step=1 moves to COMPUTE with r=0 and sets busy=1.
    - If load_en and step are high together, load wins and step is dropped.
  - COMPUTE:
    - Each cycle computes shadow[r] from cur rows r-1, r, r+1, then r increments.
    - After r=ROWS-1 the next state is COMMIT.
    - step and load_en are ignored (not queued).
  - COMMIT (one cycle):
    - cur<=shadow.
    - gen_count<=gen_count+1, wrapping at 2^GENW to 0.
    - population<=popcount(shadow).
    - stable<=(shadow==cur).
    - Next state is IDLE, busy falls, done=1 for the following cycle.
- Latency: step sampled at edge N gives busy=1 from N. grid_flat changes at edge N+ROWS+1, and done is high during the cycle after that edge.
- Throughput: back-to-back steps need step asserted in IDLE. Minimum period is ROWS+2 cycles.
- Cell rule:
  - n = count of the 8 neighbours, 4-bit, range 0..8.
  - next = (n==3) | (alive & n==2).
- Edge rule: when WRAP=1, row -1 maps to ROWS-1 and col COLS maps to 0. When WRAP=0, out-of-range neighbours count as 0.
- Output timing: grid_flat reflects cur only and is constant throughout COMPUTE, so it is glitch-free for the downstream scanner.
- load_row >= ROWS (non-power-of-2 ROWS) is ignored; grid unchanged.
- gen_count is unaffected by loads. It is cleared only by reset.

Test Plan:
- Reset: hold _rst low 3 cycles, assert step during reset → grid_flat=0, gen_count=0, population=0, busy=0, done never pulses. Release → IDLE.
- Blinker (8x8, WRAP=1):
  - load row3=0x1C, step → busy 9 cycles (8 COMPUTE + 1 COMMIT), then done pulse; rows 2,3,4=0x08, others 0, population=3, gen_count=1, stable=0.
  - Step again → row3=0x1C only, gen_count=2.
- Block still life: load rows1,2=0x06, step → grid unchanged, stable=1, population=4. A subsequent load of any row clears stable.
- Edge handling: load row0=0x07, step.
  - WRAP=1: rows 7,0,1=0x02.
  - WRAP=0 build: rows 0,1=0x02 and row7=0x00.
- Busy and simultaneous events:
  - Pulse step and load_en at compute cycle 3 → both ignored, single done, gen_count+1 only.
  - In IDLE, assert load_en(row5=0xFF) and step in the same cycle → row5=0xFF loaded, busy stays 0.
- Reset mid-compute: assert _rst asynchronously (off clock edge) at COMPUTE cycle 4 → outputs zero immediately, no done pulse. A new step after release works normally from an empty grid (stays empty, gen_count=1).
